// File: rtl/exec_stage_pipe_if.sv
// Handshaked issue/result bundle between the execute stage and its neighbours.
// Upstream fields flow in, the registered result bundle flows out to memory.
interface exec_stage_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       br_type;
    logic [WIDTH-1:0] br_base;
    logic [WIDTH-1:0] br_off;
    logic [2:0]       dest;
    logic             wr_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       dest_out;
    logic             wr_en_out;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             err;

    modport master (
        output in_valid, flush, op, a, b, br_type,
        output br_base, br_off, dest, wr_en, out_ready,
        input  in_ready, out_valid, result, dest_out,
        input  wr_en_out, br_taken, br_target, err
    );

    modport slave (
        input  in_valid, flush, op, a, b, br_type,
        input  br_base, br_off, dest, wr_en, out_ready,
        output in_ready, out_valid, result, dest_out,
        output wr_en_out, br_taken, br_target, err
    );
endinterface

// File: rtl/exec_stage_pipe.sv
// Execute stage: single-cycle ALU/set/branch plus a bit-serial multiplier,
// feeding one output register held under back-pressure.
module exec_stage_pipe #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    exec_stage_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, stateNext;

    logic             outValid, wrEnOut, brTaken, errOut;
    logic [WIDTH-1:0] result, brTarget;
    logic [2:0]       destOut;

    logic [WIDTH-1:0] mcand, mplier, acc, accNext;
    logic [CW-1:0]    cnt;
    logic [2:0]       pendDest;
    logic             pendWrEn, pendTaken, pendErr;
    logic [WIDTH-1:0] pendTarget;

    logic             slotFree, accept, isMul, lastStep;
    logic             aluWrite, mulWrite;
    logic [WIDTH-1:0] aluRes, tgtNew;
    logic [WIDTH:0]   sumC;
    logic             opErr, brErr, takenNew;

    assign slotFree = ~outValid | bus.out_ready;
    assign bus.in_ready = rst & ~bus.flush & (state == IDLE) & slotFree;
    assign accept = bus.in_valid & bus.in_ready;
    assign isMul = (bus.op == 4'd8);
    assign aluWrite = accept & ~isMul;
    assign lastStep = (cnt == CW'(WIDTH - 1));
    assign accNext = acc + (mplier[0] ? mcand : '0);
    assign sumC = {1'b0, bus.a} + {1'b0, bus.b};
    assign tgtNew = bus.br_base + bus.br_off;

    always_comb begin
        aluRes = '0;
        opErr = 1'b0;
        unique case (bus.op)
            4'd0:  aluRes = sumC[WIDTH-1:0];
            4'd1:  aluRes = bus.a - bus.b;
            4'd2:  aluRes = bus.a & bus.b;
            4'd3:  aluRes = bus.a | bus.b;
            4'd4:  aluRes = bus.a ^ bus.b;
            4'd5:  aluRes = bus.a << bus.b[3:0];
            4'd6:  aluRes = bus.a >> bus.b[3:0];
            4'd7:  aluRes = $signed(bus.a) >>> bus.b[3:0];
            4'd8:  aluRes = '0;
            4'd9:  aluRes = WIDTH'(bus.a == bus.b);
            4'd10: aluRes = WIDTH'($signed(bus.a) < $signed(bus.b));
            4'd11: aluRes = WIDTH'($signed(bus.a) <= $signed(bus.b));
            4'd12: aluRes = WIDTH'(sumC[WIDTH]);
            default: opErr = 1'b1;
        endcase
    end

    always_comb begin
        takenNew = 1'b0;
        brErr = 1'b0;
        unique case (bus.br_type)
            3'd0: takenNew = 1'b0;
            3'd1: takenNew = (bus.a == '0);
            3'd2: takenNew = (bus.a != '0);
            3'd3: takenNew = bus.a[WIDTH-1];
            3'd4: takenNew = ~bus.a[WIDTH-1];
            default: brErr = 1'b1;
        endcase
    end

    always_comb begin
        stateNext = state;
        mulWrite = 1'b0;
        unique case (state)
            IDLE: if (accept && isMul) stateNext = MUL;
            MUL: begin
                if (lastStep) begin
                    if (slotFree) begin
                        mulWrite = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (slotFree) begin
                    mulWrite = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (bus.flush) begin
            stateNext = IDLE;
            mulWrite = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // In DONE the last step has already run, so acc holds the product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            cnt <= '0;
            pendDest <= '0;
            pendWrEn <= 1'b0;
            pendTaken <= 1'b0;
            pendTarget <= '0;
            pendErr <= 1'b0;
        end else if (bus.flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept && isMul) begin
            mcand <= bus.a;
            mplier <= bus.b;
            acc <= '0;
            cnt <= '0;
            pendDest <= bus.dest;
            pendWrEn <= bus.wr_en;
            pendTaken <= takenNew;
            pendTarget <= tgtNew;
            pendErr <= brErr;
        end else if (state == MUL) begin
            acc <= accNext;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid <= 1'b0;
            result <= '0;
            destOut <= '0;
            wrEnOut <= 1'b0;
            brTaken <= 1'b0;
            brTarget <= '0;
            errOut <= 1'b0;
        end else if (bus.flush) begin
            outValid <= 1'b0;
        end else if (aluWrite) begin
            outValid <= 1'b1;
            result <= aluRes;
            destOut <= bus.dest;
            wrEnOut <= bus.wr_en;
            brTaken <= takenNew;
            brTarget <= tgtNew;
            errOut <= opErr | brErr;
        end else if (mulWrite) begin
            outValid <= 1'b1;
            result <= (state == DONE) ? acc : accNext;
            destOut <= pendDest;
            wrEnOut <= pendWrEn;
            brTaken <= pendTaken;
            brTarget <= pendTarget;
            errOut <= pendErr;
        end else if (bus.out_ready) begin
            outValid <= 1'b0;
        end
    end

    assign bus.out_valid = outValid;
    assign bus.result = result;
    assign bus.dest_out = destOut;
    assign bus.wr_en_out = wrEnOut;
    assign bus.br_taken = brTaken;
    assign bus.br_target = brTarget;
    assign bus.err = errOut;
endmodule

// File: doc/exec_stage_pipe.md
# exec_stage_pipe

Parametrised, handshaked execute stage for the pipelined core. It accepts one decoded instruction per cycle under valid/ready flow control and computes ALU results, set-condition values and branch decisions. A bit-serial multiplier runs in the same slot and stalls upstream while busy. Results sit in a single output register held under downstream back-pressure, and a synchronous flush kills all in-flight work; the stage feeds the memory stage.

## Interface
- WIDTH, 16, datapath width (≥4); also the multiply iteration count
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; combinational
- flush  in  1  synchronous kill of everything in the stage
- op  in  4  0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift by b[3:0]), 8 MUL (low WIDTH bits), 9 SEQ, 10 SLT (signed), 11 SLE (signed), 12 SCO (carry of a+b); 13–15 illegal
- a, b  in  WIDTH  operands (rs, second source already muxed)
- br_type  in  3  0 none, 1 a==0, 2 a!=0, 3 a<0, 4 a≥0; 5–7 illegal
- br_base, br_off  in  WIDTH  branch base and pre-extended offset
- dest  in  3  destination register
- wr_en  in  1  register write enable
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream accepts
- result  out  WIDTH  ALU, set or product value
- dest_out, wr_en_out  out  3, 1  registered copies
- br_taken  out  1  branch resolved taken
- br_target  out  WIDTH  br_base+br_off, modulo 2^WIDTH
- err  out  1  illegal op or br_type for this result

## Operation
- Accept occurs when in_valid & in_ready.
- in_ready = rst & ~flush & (state==IDLE) & (~out_valid | out_ready).
- **Single-cycle ops:** all fields are captured into the output register on the accept edge.
  - SEQ, SLT, SLE and SCO produce 1 or 0, zero-extended.
  - Adds and subtracts wrap modulo 2^WIDTH.
- **MUL FSM:** states IDLE, MUL, DONE.
  - IDLE→MUL on accepting op 8. The edge loads the multiplicand, multiplier and a zero accumulator, and clears the counter.
  - In MUL, each edge does one shift-add step and increments the counter.
  - After the final step the FSM writes the output register if it is free (~out_valid | out_ready) and goes to IDLE. Otherwise it goes to DONE.
  - DONE→IDLE writes the output register on the first edge where the slot is free.
  - dest, wr_en and the branch fields are latched at accept and emitted with the product.
- **Output hold:** with out_valid & ~out_ready, every output is held stable.
  - out_valid clears on an edge with out_ready and no new write.
- **Branch:** br_taken is evaluated on a per br_type; br_target is always computed. MUL with br_type≠0 is legal.
- **Errors:** an illegal op gives result 0 and err 1. An illegal br_type gives br_taken 0 and err 1. In both cases the stage still produces out_valid and never hangs.
- **Flush:**
  - The next edge clears out_valid, forces the FSM to IDLE and discards the multiplier contents.
  - in_ready is 0 during the flush cycle, so nothing is accepted.
- **Reset:**
  - Asserting rst mid-operation immediately sets the FSM to IDLE.
  - out_valid, result, dest_out, wr_en_out, br_taken, br_target and err reset to 0.
  - in_ready is 0 while rst is low and 1 in the first cycle after release.

## Timing
- Single-cycle op accepted at edge N: out_valid=1 after edge N. Throughput is 1/cycle when out_ready=1.
- MUL accepted at edge N: the result is written at edge N+WIDTH (16 for the default) if the slot is free, otherwise at the first later edge with the slot free.
  - in_ready=0 from after edge N until the FSM returns to IDLE.
- flush has priority over acceptance, MUL completion and hold.
- A single-cycle op is accepted on the same edge the previous result is consumed (out_ready=1).
- No combinational path from in_valid to out_valid.
- out_ready→in_ready is combinational.

## Test plan
- **Back-to-back ADD/SUB:** ADD 0x7FFF+0x0001, then SUB 0x0000−0x0001, with out_ready=1.
  - result 0x8000 one cycle after accept, then 0xFFFF the next cycle; err=0.
- **MUL timing:** MUL a=0x0123, b=0x0045.
  - result 0x4E6F with out_valid rising exactly 16 edges after accept.
  - in_ready=0 throughout; dest and wr_en preserved.
- **Back-pressure:** out_ready=0 during a SLT of 0xFFFE<0x0001 (result 1), then hold for 5 cycles.
  - Outputs stay stable and in_ready=0.
  - On release the result is consumed and the next instruction is accepted on the same edge.
- **Branch:** br_type=3, a=0x8000, br_base=0x0010, br_off=0xFFFE.
  - br_taken=1, br_target=0x000E.
  - The same with a=0x0000 gives br_taken=0.
- **Flush mid-MUL:** flush 5 cycles after accepting a MUL.
  - out_valid stays 0 and in_ready returns 1 the next cycle.
  - A following ADD 2+3 gives 0x0005.
- **Illegal and reset cases:** op=14 gives out_valid=1, err=1, result=0. Asserting rst mid-MUL makes all outputs 0 immediately, and no result appears after release.
